// File: rtl/cct_xyz_interp_if.sv
// Handshake and table-load bundle for the CCT to XYZ white-point converter.
// The slave modport is the converter's view; master is the producer/consumer side.
interface cct_xyz_interp_if #(
  parameter int FRAC_BITS = 16,
  parameter int DATA_W    = 32,
  parameter int NUM_PTS   = 17
);
  localparam int ADDR_W = $clog2(NUM_PTS);

  logic [15:0]            cct_in;
  logic                   cct_valid;
  logic                   cct_ready;
  logic                   tbl_we;
  logic [ADDR_W-1:0]      tbl_addr;
  logic [2*FRAC_BITS-1:0] tbl_data;
  logic [3*DATA_W-1:0]    xyz_out;
  logic                   xyz_valid;
  logic                   xyz_ready;
  logic [2:0]             status;

  modport slave (
    input  cct_in, cct_valid, tbl_we, tbl_addr, tbl_data, xyz_ready,
    output cct_ready, xyz_out, xyz_valid, status
  );

  modport master (
    output cct_in, cct_valid, tbl_we, tbl_addr, tbl_data, xyz_ready,
    input  cct_ready, xyz_out, xyz_valid, status
  );
endinterface

// File: rtl/cct_xyz_interp.sv
// Colour temperature to white-point XYZ (Y = 1.0): interpolates a programmable xy table,
// then derives X = x/y and Z = (1-x-y)/y with one shared bit-serial restoring divider.
module cct_xyz_interp #(
  parameter int FRAC_BITS = 16,
  parameter int DATA_W    = 32,
  parameter int CCT_MIN   = 2500,
  parameter int SEG_SHIFT = 9,
  parameter int NUM_PTS   = 17
) (
  input logic             clk,
  input logic             rst_n,
  cct_xyz_interp_if.slave bus
);
  localparam int CW      = 16;
  localparam int CCT_MAX = CCT_MIN + ((NUM_PTS - 1) << SEG_SHIFT);
  localparam int ADDR_W  = $clog2(NUM_PTS);
  localparam int DW      = FRAC_BITS + 1;
  localparam int PW      = DW + SEG_SHIFT + 1;
  localparam int CNT_W   = $clog2(DATA_W);

  localparam logic [CW-1:0]     CMIN      = CW'(CCT_MIN);
  localparam logic [CW-1:0]     CMAX      = CW'(CCT_MAX);
  localparam logic [ADDR_W:0]   NUM_PTS_W = (ADDR_W + 1)'(NUM_PTS);
  localparam logic [ADDR_W-1:0] LAST_SEG  = ADDR_W'(NUM_PTS - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [DW-1:0]     ONE_Q     = DW'(1) << FRAC_BITS;
  localparam logic [DATA_W-1:0] Y_ONE     = DATA_W'(1) << FRAC_BITS;

  typedef enum logic [2:0] {IDLE, INTERP, DIV_X, DIV_Z, OUT} state_t;

  state_t                 state;
  logic [FRAC_BITS-1:0]   x_tbl [NUM_PTS];
  logic [FRAC_BITS-1:0]   y_tbl [NUM_PTS];
  logic [CW-1:0]          c_reg;
  logic [FRAC_BITS-1:0]   div_y;
  logic [FRAC_BITS-1:0]   nz_reg;
  logic [DATA_W-1:0]      div_n;
  logic [FRAC_BITS-1:0]   div_rem;
  logic [DATA_W-1:0]      div_q;
  logic [CNT_W-1:0]       div_cnt;
  logic [DATA_W-1:0]      x_res;

  logic [CW-1:0]          c_in;
  logic [CW-1:0]          d;
  logic [ADDR_W-1:0]      seg;
  logic [ADDR_W-1:0]      seg_nx;
  logic [SEG_SHIFT-1:0]   f;
  logic signed [DW-1:0]   dx;
  logic signed [DW-1:0]   dy;
  logic signed [PW-1:0]   px;
  logic signed [PW-1:0]   py;
  logic [FRAC_BITS-1:0]   x_i;
  logic [FRAC_BITS-1:0]   y_i;
  logic [DW-1:0]          sum;
  logic [FRAC_BITS-1:0]   nz_c;
  logic [DW-1:0]          rem_sh;
  logic                   ge;
  logic [FRAC_BITS-1:0]   rem_nx;
  logic [DATA_W-1:0]      q_nx;

  // Table writes are accepted in any state; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PTS; i++) begin
        x_tbl[i] <= '0;
        y_tbl[i] <= '0;
      end
    end else if (bus.tbl_we && ({1'b0, bus.tbl_addr} < NUM_PTS_W)) begin
      x_tbl[bus.tbl_addr] <= bus.tbl_data[FRAC_BITS-1:0];
      y_tbl[bus.tbl_addr] <= bus.tbl_data[2*FRAC_BITS-1:FRAC_BITS];
    end
  end

  // Interpolation floors toward -inf because the signed product is shifted arithmetically.
  always_comb begin
    c_in   = (bus.cct_in < CMIN) ? CMIN : ((bus.cct_in > CMAX) ? CMAX : bus.cct_in);
    d      = c_reg - CMIN;
    seg    = ADDR_W'(d >> SEG_SHIFT);
    f      = d[SEG_SHIFT-1:0];
    seg_nx = (seg == LAST_SEG) ? seg : seg + 1'b1;
    dx     = $signed({1'b0, x_tbl[seg_nx]}) - $signed({1'b0, x_tbl[seg]});
    dy     = $signed({1'b0, y_tbl[seg_nx]}) - $signed({1'b0, y_tbl[seg]});
    px     = PW'(dx) * PW'($signed({1'b0, f}));
    py     = PW'(dy) * PW'($signed({1'b0, f}));
    x_i    = FRAC_BITS'(PW'($signed({1'b0, x_tbl[seg]})) + (px >>> SEG_SHIFT));
    y_i    = FRAC_BITS'(PW'($signed({1'b0, y_tbl[seg]})) + (py >>> SEG_SHIFT));
    sum    = {1'b0, x_i} + {1'b0, y_i};
    nz_c   = sum[FRAC_BITS] ? '0 : FRAC_BITS'(ONE_Q - sum);
    rem_sh = {div_rem, div_n[DATA_W-1]};
    ge     = (rem_sh >= {1'b0, div_y});
    rem_nx = ge ? FRAC_BITS'(rem_sh - {1'b0, div_y}) : rem_sh[FRAC_BITS-1:0];
    q_nx   = (div_q << 1) | DATA_W'(ge);
  end

  // Main sequencer; the divider state is reloaded between the X and Z passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.cct_ready <= 1'b1;
      bus.xyz_valid <= 1'b0;
      bus.xyz_out   <= '0;
      bus.status    <= '0;
      c_reg         <= '0;
      div_y         <= '0;
      nz_reg        <= '0;
      div_n         <= '0;
      div_rem       <= '0;
      div_q         <= '0;
      div_cnt       <= '0;
      x_res         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cct_valid) begin
            c_reg         <= c_in;
            bus.status    <= {(c_in != bus.cct_in), 2'b00};
            bus.cct_ready <= 1'b0;
            state         <= INTERP;
          end
        end
        INTERP: begin
          div_y         <= y_i;
          nz_reg        <= nz_c;
          bus.status[0] <= (y_i == '0);
          bus.status[1] <= sum[FRAC_BITS];
          div_n         <= DATA_W'(x_i) << FRAC_BITS;
          div_rem       <= '0;
          div_q         <= '0;
          div_cnt       <= '0;
          state         <= DIV_X;
        end
        DIV_X: begin
          div_n   <= div_n << 1;
          div_rem <= rem_nx;
          div_q   <= q_nx;
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == LAST_BIT) begin
            x_res   <= bus.status[0] ? '1 : q_nx;
            div_n   <= DATA_W'(nz_reg) << FRAC_BITS;
            div_rem <= '0;
            div_q   <= '0;
            div_cnt <= '0;
            state   <= DIV_Z;
          end
        end
        DIV_Z: begin
          div_n   <= div_n << 1;
          div_rem <= rem_nx;
          div_q   <= q_nx;
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == LAST_BIT) begin
            bus.xyz_out   <= {(bus.status[0] ? {DATA_W{1'b1}} : q_nx), Y_ONE, x_res};
            bus.xyz_valid <= 1'b1;
            state         <= OUT;
          end
        end
        OUT: begin
          if (bus.xyz_ready) begin
            bus.xyz_valid <= 1'b0;
            bus.cct_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.xyz_valid <= 1'b0;
          bus.cct_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cct_xyz_interp.sv
// Scoreboard bench for cct_xyz_interp: directed spot values plus randomized tables and
// CCTs checked against an arithmetic reference model of the converter.
module tb_cct_xyz_interp;
  localparam int CCT_MIN = 2500;
  localparam int CCT_MAX = 10692;
  localparam int NPTS    = 17;

  typedef struct {
    logic [95:0] xyz;
    logic [2:0]  st;
    int          cct;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   tx [NPTS];
  int   ty [NPTS];
  exp_t expQ [$];
  bit   randomMode;
  bit   holdOff;

  cct_xyz_interp_if #(.FRAC_BITS(16), .DATA_W(32), .NUM_PTS(17)) bus ();

  cct_xyz_interp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic int floorDiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic exp_t mk(input longint xv, input longint zv, input logic [2:0] st, input int cct);
    exp_t e;
    e.xyz = {zv[31:0], 32'h0001_0000, xv[31:0]};
    e.st  = st;
    e.cct = cct;
    return e;
  endfunction

  // Reference: clamp, piecewise-linear xy, then plain integer division.
  function automatic exp_t modelConvert(input int cct);
    int c, d, seg, f, x, y, nz;
    logic [2:0] st;
    longint xv, zv;
    st = 3'b000;
    c  = (cct < CCT_MIN) ? CCT_MIN : ((cct > CCT_MAX) ? CCT_MAX : cct);
    st[2] = (c != cct);
    d   = c - CCT_MIN;
    seg = d / 512;
    f   = d % 512;
    if (seg == NPTS - 1) begin
      x = tx[seg];
      y = ty[seg];
    end else begin
      x = tx[seg] + floorDiv((tx[seg+1] - tx[seg]) * f, 512);
      y = ty[seg] + floorDiv((ty[seg+1] - ty[seg]) * f, 512);
    end
    if (x + y >= 65536) begin
      nz = 0;
      st[1] = 1'b1;
    end else begin
      nz = 65536 - x - y;
    end
    if (y == 0) begin
      xv = 64'hFFFF_FFFF;
      zv = 64'hFFFF_FFFF;
      st[0] = 1'b1;
    end else begin
      xv = (longint'(x) * 65536) / y;
      zv = (longint'(nz) * 65536) / y;
    end
    return mk(xv, zv, st, cct);
  endfunction

  task automatic writeEntry(input int addr, input int x, input int y);
    @(posedge clk); #1;
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = 5'(addr);
    bus.tbl_data = {16'(y), 16'(x)};
    @(posedge clk); #1;
    bus.tbl_we = 1'b0;
    if (addr < NPTS) begin
      tx[addr] = x;
      ty[addr] = y;
    end
  endtask

  // Issues one sample, queues its expectation and checks the 65-edge latency.
  task automatic applyStimulus(input int cct, input exp_t e);
    bit accepted;
    int lat;
    @(posedge clk); #1;
    bus.cct_in    = 16'(cct);
    bus.cct_valid = 1'b1;
    expQ.push_back(e);
    accepted = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.cct_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      bus.cct_valid = 1'b0;
      checkOutput("accept_timeout", 96'd0, 96'd1);
      return;
    end
    @(posedge clk); #1;
    bus.cct_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (bus.xyz_valid) begin
        lat = i;
        break;
      end
    end
    checkOutput($sformatf("latency cct=%0d", cct), 96'(lat), 96'd65);
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) break;
    end
    checkOutput("drain", 96'(expQ.size()), 96'd0);
    expQ.delete();
  endtask

  task automatic loadRandomTable();
    for (int i = 0; i < NPTS; i++)
      writeEntry(i, int'($urandom_range(0, 65535)),
                 ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 65535)));
  endtask

  // Backpressure driver: always ready, random, or left to the main sequence.
  initial begin
    bus.xyz_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!holdOff) bus.xyz_ready = randomMode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor pops one expectation per completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.xyz_valid && bus.xyz_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 96'd1, 96'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("xyz_out cct=%0d", e.cct), bus.xyz_out, e.xyz);
          checkOutput($sformatf("status cct=%0d", e.cct), 96'(bus.status), 96'(e.st));
        end
      end
    end
  end

  initial begin
    int cct;
    int sawValid;
    exp_t e;
    int edgeCcts [6] = '{2499, 2500, 10692, 10693, 3012, 0};
    checks = 0;
    failures = 0;
    randomMode = 1'b0;
    holdOff = 1'b0;
    for (int i = 0; i < NPTS; i++) begin
      tx[i] = 0;
      ty[i] = 0;
    end
    bus.cct_in = '0;
    bus.cct_valid = 1'b0;
    bus.tbl_we = 1'b0;
    bus.tbl_addr = '0;
    bus.tbl_data = '0;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset xyz_valid", 96'(bus.xyz_valid), 96'd0);
    checkOutput("reset cct_ready", 96'(bus.cct_ready), 96'd1);
    checkOutput("reset xyz_out", bus.xyz_out, 96'd0);
    checkOutput("reset status", 96'(bus.status), 96'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NPTS; i++) writeEntry(i, 'h5000, 'h5000);
    applyStimulus(6500, mk(64'h0001_0000, 64'h0001_3333, 3'b000, 6500));

    writeEntry(0, 'h4000, 'h4000);
    writeEntry(1, 'h6000, 'h4000);
    applyStimulus(2756, mk(64'h0001_4000, 64'h0001_C000, 3'b000, 2756));

    applyStimulus(1000, mk(64'h0001_0000, 64'h0002_0000, 3'b100, 1000));
    applyStimulus(20000, mk(64'h0001_0000, 64'h0001_3333, 3'b100, 20000));
    applyStimulus(10692, mk(64'h0001_0000, 64'h0001_3333, 3'b000, 10692));

    writeEntry(20, 'hFFFF, 'h0000);
    writeEntry(2, 'h3000, 'h0000);
    writeEntry(3, 'hC000, 'h8000);
    applyStimulus(3524, mk(64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b001, 3524));
    applyStimulus(4036, mk(64'h0001_8000, 64'h0000_0000, 3'b010, 4036));
    applyStimulus(2756, mk(64'h0001_4000, 64'h0001_C000, 3'b000, 2756));
    drainQueue();

    randomMode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0) loadRandomTable();
      cct = (n % 7 == 0) ? edgeCcts[(n / 7) % 6] : int'($urandom_range(0, 20000));
      applyStimulus(cct, modelConvert(cct));
    end
    drainQueue();
    randomMode = 1'b0;

    // Stalled output must hold steady while a stray request is ignored.
    @(negedge clk);
    holdOff = 1'b1;
    bus.xyz_ready = 1'b0;
    e = modelConvert(5000);
    applyStimulus(5000, e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall xyz_valid", 96'(bus.xyz_valid), 96'd1);
      checkOutput("stall xyz_out", bus.xyz_out, e.xyz);
      checkOutput("stall status", 96'(bus.status), 96'(e.st));
      checkOutput("stall cct_ready", 96'(bus.cct_ready), 96'd0);
      if (i == 2) begin
        bus.cct_in = 16'd3000;
        bus.cct_valid = 1'b1;
      end
      if (i == 5) bus.cct_valid = 1'b0;
    end
    holdOff = 1'b0;
    drainQueue();
    repeat (80) @(negedge clk);
    checkOutput("stray request ignored", 96'(bus.cct_ready), 96'd1);

    // Abort a conversion mid-divide with reset.
    @(posedge clk); #1;
    bus.cct_in = 16'd6000;
    bus.cct_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cct_ready) break;
    end
    @(posedge clk); #1;
    bus.cct_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NPTS; i++) begin
      tx[i] = 0;
      ty[i] = 0;
    end
    #1;
    checkOutput("abort xyz_valid", 96'(bus.xyz_valid), 96'd0);
    checkOutput("abort cct_ready", 96'(bus.cct_ready), 96'd1);
    checkOutput("abort xyz_out", bus.xyz_out, 96'd0);
    checkOutput("abort status", 96'(bus.status), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.xyz_valid) sawValid++;
    end
    checkOutput("abort no output", 96'(sawValid), 96'd0);

    applyStimulus(6500, mk(64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b001, 6500));
    drainQueue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
